// File: rtl/ram_capture_pkg.sv
// ----------------------------------------------------------------------------
// ram_capture_pkg
// Shared definitions for the RAM capture scheduler: FSM state encoding, the
// bit positions of the fields in the PS-side GPIO control word, and a small
// helper that clamps the requested capture length to what the BRAM can hold.
// No ports (package).
// ----------------------------------------------------------------------------
package ram_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int ENABLE_BIT  = 0;
    localparam int REQUEST_BIT = 1;
    localparam int LEN_LSB     = 2;
    localparam int LEN_MSB     = 6;
    localparam int THR_LSB     = 7;
    localparam int THR_MSB     = 11;

    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    localparam int THR_W = THR_MSB - THR_LSB + 1;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] value,
                                                    input int unsigned     limit);
        if (32'(value) > limit) begin
            return LEN_W'(limit);
        end
        return value;
    endfunction

endpackage

// File: rtl/ram_capture_sched_if.sv
// ----------------------------------------------------------------------------
// ram_capture_sched_if
// Groups the sample stream (AXI-Stream slave side) and the BRAM write port of
// the capture scheduler.
//   S_AXIS_tvalid / S_AXIS_tdata : incoming samples
//   S_AXIS_tready                : stream ready (never stalls after reset)
//   wr_en / wr_addr / wr_data    : BRAM write port
// Modports:
//   master : the environment (stream source and BRAM sink)
//   slave  : the scheduler
// ----------------------------------------------------------------------------
interface ram_capture_sched_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  S_AXIS_tvalid;
    logic [DATA_WIDTH-1:0] S_AXIS_tdata;
    logic                  S_AXIS_tready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output S_AXIS_tvalid, S_AXIS_tdata,
        input  S_AXIS_tready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  S_AXIS_tvalid, S_AXIS_tdata,
        output S_AXIS_tready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ram_capture_throttle.sv
// ----------------------------------------------------------------------------
// ram_capture_throttle
// Decimation counter for the capture scheduler. Every accepted beat bumps a
// free-running 32-bit counter (wraps modulo 2^32); a beat is qualified for
// writing when the post-increment count has its low log_throttle bits clear,
// so one beat in every 2^log_throttle is kept.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : zero the counter (start of a capture)
//   beat          : a valid sample is being offered while capturing
//   log_throttle  : decimation exponent (0 keeps every beat)
//   qualify       : this beat is to be written
// ----------------------------------------------------------------------------
module ram_capture_throttle
    import ram_capture_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             beat,
    input  logic [THR_W-1:0] log_throttle,
    output logic             qualify
);

    logic [31:0] count_q;
    logic [31:0] count_next;
    logic [31:0] mask;

    // The decision looks at the count after this beat is added, so the last
    // beat of each 2^log_throttle group is the one that gets written.
    always_comb begin
        count_next = count_q + 32'd1;
        mask       = (32'd1 << log_throttle) - 32'd1;
        qualify    = beat && ((count_next & mask) == 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (beat) begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/ram_capture_sched.sv
// ----------------------------------------------------------------------------
// ram_capture_sched
// Sequences the RAM writer datapath: a rising edge on the GPIO request bit
// (with enable set) captures 2^log_length decimated samples into one half of
// the BRAM, then flips to the other half so the PS can read the finished one.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   GPIO          : [0] enable, [1] request, [6:2] log_length,
//                   [11:7] log_throttle, [31:12] ignored
//   axis_bus      : sample stream in, BRAM write port out (slave modport)
//   busy          : capture armed or in progress
//   done          : one-cycle pulse when a buffer completes
//   ready_buf     : half holding the most recent complete capture
//   overflow      : sticky, request seen while busy; cleared by enable=0
//   seq_count     : buffer sequence number (only with RAM_CAPTURE_SEQ_EN)
// Optional feature macro: RAM_CAPTURE_SEQ_EN -- adds seq_count and stamps it
// into word 0 of every buffer in place of the sample for that slot.
// ----------------------------------------------------------------------------
module ram_capture_sched
    import ram_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [31:0]          GPIO,
    ram_capture_sched_if.slave   axis_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 ready_buf,
    output logic                 overflow
`ifdef RAM_CAPTURE_SEQ_EN
    ,
    output logic [31:0]          seq_count
`endif
);

    cap_state_t            state_q;
    cap_state_t            state_next;

    logic                  enable;
    logic                  request;
    logic                  req_q;
    logic                  req_edge;
    logic                  start;
    logic                  finish;
    logic                  beat;
    logic                  write_fire;
    logic                  last_write;

    logic [LEN_W-1:0]      len_q;
    logic [THR_W-1:0]      thr_q;
    logic [ADDR_WIDTH-1:0] wr_count_q;
    logic [ADDR_WIDTH-1:0] target;
    logic                  half_q;

    logic                  tready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] sample;
    logic                  done_q;
    logic                  ready_buf_q;
    logic                  overflow_q;
    logic                  gpio_unused;

`ifdef RAM_CAPTURE_SEQ_EN
    logic [31:0]           seq_q;
`endif

    assign enable      = GPIO[ENABLE_BIT];
    assign request     = GPIO[REQUEST_BIT];
    assign req_edge    = request && !req_q;
    assign gpio_unused = ^GPIO[31:THR_MSB+1];

    // Beats only count while capturing; dropping enable gates them at once so
    // an abort never produces a trailing write strobe.
    assign beat = (state_q == CAPTURE) && enable && axis_bus.S_AXIS_tvalid;

    ram_capture_throttle u_throttle (
        .clk          (aclk),
        .rst_n        (aresetn),
        .clear        (state_q == ARM),
        .beat         (beat),
        .log_throttle (thr_q),
        .qualify      (write_fire)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next state and decoded controls. enable=0 overrides everything and
    // returns to IDLE without completing the buffer.
    always_comb begin
        state_next = state_q;
        busy       = (state_q == ARM) || (state_q == CAPTURE);
        target     = ADDR_WIDTH'(1) << len_q;
        last_write = write_fire && ((wr_count_q + ADDR_WIDTH'(1)) == target);
        start      = (state_q == IDLE) && enable && req_edge;
        finish     = (state_q == DONE) && enable;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (req_edge)   state_next = ARM;
                ARM:                     state_next = CAPTURE;
                CAPTURE: if (last_write) state_next = DONE;
                DONE:                    state_next = IDLE;
                default:                 state_next = IDLE;
            endcase
        end
    end

    // With the sequence feature, slot 0 carries the buffer number instead of
    // the sample; the beat is still consumed so decimation phase is kept.
    always_comb begin
        sample = axis_bus.S_AXIS_tdata;
`ifdef RAM_CAPTURE_SEQ_EN
        if (wr_count_q == '0) begin
            sample = DATA_WIDTH'(seq_q);
        end
`endif
    end

    // Datapath registers: request edge detect, latched capture geometry,
    // write counter, registered BRAM write, and buffer hand-off status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_q       <= 1'b0;
            len_q       <= '0;
            thr_q       <= '0;
            wr_count_q  <= '0;
            half_q      <= 1'b0;
            tready_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            ready_buf_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            req_q    <= request;
            tready_q <= 1'b1;
            wr_en_q  <= write_fire;
            done_q   <= finish;
            if (start) begin
                len_q <= clamp_len(GPIO[LEN_MSB:LEN_LSB], ADDR_WIDTH - 1);
                // The 5-bit field cannot exceed 31, so it is taken as is.
                thr_q <= GPIO[THR_MSB:THR_LSB];
            end
            if (state_q == ARM) begin
                wr_count_q <= '0;
            end else if (write_fire) begin
                wr_count_q <= wr_count_q + ADDR_WIDTH'(1);
            end
            if (write_fire) begin
                wr_addr_q <= {half_q, wr_count_q[ADDR_WIDTH-2:0]};
                wr_data_q <= sample;
            end
            if (finish) begin
                ready_buf_q <= half_q;
                half_q      <= ~half_q;
            end
            if (!enable) begin
                overflow_q <= 1'b0;
            end else if (req_edge && (state_q != IDLE)) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef RAM_CAPTURE_SEQ_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seq_q <= '0;
        end else if (finish) begin
            seq_q <= seq_q + 32'd1;
        end
    end

    assign seq_count = seq_q;
`endif

    assign axis_bus.S_AXIS_tready = tready_q;
    assign axis_bus.wr_en         = wr_en_q;
    assign axis_bus.wr_addr       = wr_addr_q;
    assign axis_bus.wr_data       = wr_data_q;
    assign done                   = done_q;
    assign ready_buf              = ready_buf_q;
    assign overflow               = overflow_q;

endmodule

// File: tb/tb_ram_capture_sched.sv
// ----------------------------------------------------------------------------
// tb_ram_capture_sched
// Directed self-checking bench for ram_capture_sched. Each scenario task
// drives GPIO and the sample stream cycle by cycle, logs write strobes and
// done pulses, and compares them with hand-computed expectations.
// Builds with or without RAM_CAPTURE_SEQ_EN.
// ----------------------------------------------------------------------------
module tb_ram_capture_sched;

    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 32;
    localparam int HALF       = 1 << (ADDR_WIDTH - 1);
`ifdef RAM_CAPTURE_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] GPIO;
    logic        busy;
    logic        done;
    logic        ready_buf;
    logic        overflow;
`ifdef RAM_CAPTURE_SEQ_EN
    logic [31:0] seq_count;
`endif

    ram_capture_sched_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) axis_bus ();

    ram_capture_sched #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .GPIO      (GPIO),
        .axis_bus  (axis_bus),
        .busy      (busy),
        .done      (done),
        .ready_buf (ready_buf),
        .overflow  (overflow)
`ifdef RAM_CAPTURE_SEQ_EN
        ,
        .seq_count (seq_count)
`endif
    );

    always #5 aclk = ~aclk;

    int          checks;
    int          errors;
    int          cyc;
    int          seq_model;
    logic [31:0] data_ctr;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];

    // Expected content of word 0 of a buffer: the stamped sequence number when
    // the feature is built in, otherwise the sample itself.
    function automatic logic [31:0] word0_expect(input logic [31:0] smp);
        return SEQ_EN ? 32'(seq_model) : smp;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
        cyc = 0;
    endtask

    // One clock: present a beat (tdata counts up every cycle), clock it in,
    // then log what the DUT shows 1 ns after the edge.
    task automatic step(input logic valid);
        axis_bus.S_AXIS_tvalid = valid;
        axis_bus.S_AXIS_tdata  = data_ctr;
        @(posedge aclk);
        #1;
        data_ctr = data_ctr + 32'd1;
        cyc++;
        if (axis_bus.wr_en === 1'b1) begin
            wr_addr_q.push_back(int'(axis_bus.wr_addr));
            wr_data_q.push_back(axis_bus.wr_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) done_cyc_q.push_back(cyc);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        GPIO = 32'h0;
        axis_bus.S_AXIS_tvalid = 1'b0;
        axis_bus.S_AXIS_tdata  = '0;
        data_ctr = 32'd100;
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if ({axis_bus.S_AXIS_tready, axis_bus.wr_en, busy, done, ready_buf, overflow} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {axis_bus.S_AXIS_tready, axis_bus.wr_en, busy, done, ready_buf, overflow});
        end
        checks++;
        if (axis_bus.wr_addr !== '0 || axis_bus.wr_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got addr %0h data %0h expected 0 0",
                     axis_bus.wr_addr, axis_bus.wr_data);
        end
        aresetn = 1'b1;
        step(1'b0);
        checks++;
        if (axis_bus.S_AXIS_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tready_after_reset: got %b expected 1", axis_bus.S_AXIS_tready);
        end
    endtask

    // log_length=3, no decimation: 8 consecutive words, twice, one per half.
    task automatic test_basic();
        logic [31:0] d0;
        logic [31:0] exp_d;
        for (int pass = 0; pass < 2; pass++) begin
            clear_log();
            d0 = data_ctr;
            GPIO = 32'h0F;
            step(1'b1);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL basic_busy_arm: got %b expected 1", busy);
            end
            GPIO = 32'h0D;
            repeat (13) step(1'b1);
            checks++;
            if (wr_addr_q.size() != 8) begin
                errors++;
                $display("[TB] FAIL basic_write_count pass %0d: got %0d expected 8", pass, wr_addr_q.size());
            end
            for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
                exp_d = (i == 0) ? word0_expect(d0 + 32'd2) : d0 + 32'd2 + 32'(i);
                checks++;
                if (wr_addr_q[i] !== pass * HALF + i) begin
                    errors++;
                    $display("[TB] FAIL basic_addr[%0d]: got %0d expected %0d", i, wr_addr_q[i], pass * HALF + i);
                end
                checks++;
                if (wr_data_q[i] !== exp_d) begin
                    errors++;
                    $display("[TB] FAIL basic_data[%0d]: got %0d expected %0d", i, wr_data_q[i], exp_d);
                end
            end
            checks++;
            if (wr_cyc_q.size() == 0 || wr_cyc_q[0] != 3) begin
                errors++;
                $display("[TB] FAIL basic_first_write_latency: got cycle %0d expected 3",
                         (wr_cyc_q.size() == 0) ? -1 : wr_cyc_q[0]);
            end
            checks++;
            if (done_cyc_q.size() != 1 || done_cyc_q[0] != 11) begin
                errors++;
                $display("[TB] FAIL basic_done: got %0d pulses first at %0d expected 1 at 11",
                         done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0]);
            end
            checks++;
            if (ready_buf !== pass[0]) begin
                errors++;
                $display("[TB] FAIL basic_ready_buf: got %b expected %b", ready_buf, pass[0]);
            end
            seq_model++;
        end
    endtask

    // log_throttle=2, log_length=2: every 4th valid beat, done after 16 beats.
    task automatic test_throttle();
        logic [31:0] d0;
        logic [31:0] exp_d;
        clear_log();
        d0 = data_ctr;
        GPIO = 32'h10B;
        step(1'b1);
        GPIO = 32'h109;
        repeat (21) step(1'b1);
        checks++;
        if (wr_addr_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL throttle_write_count: got %0d expected 4", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            exp_d = (i == 0) ? word0_expect(d0 + 32'd5) : d0 + 32'd5 + 32'(4 * i);
            checks++;
            if (wr_data_q[i] !== exp_d || wr_addr_q[i] !== i) begin
                errors++;
                $display("[TB] FAIL throttle_word[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_d);
            end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 19) begin
            errors++;
            $display("[TB] FAIL throttle_done: got %0d pulses first at %0d expected 1 at 19",
                     done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0]);
        end
        checks++;
        if (ready_buf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL throttle_ready_buf: got %b expected 0", ready_buf);
        end
        seq_model++;
    endtask

    // tvalid alternating, log_length=1: writes only on valid beats.
    task automatic test_gapped();
        logic [31:0] d0;
        clear_log();
        d0 = data_ctr;
        GPIO = 32'h07;
        step(1'b1);
        GPIO = 32'h05;
        for (int s = 2; s <= 8; s++) step(s[0]);
        checks++;
        if (wr_cyc_q.size() != 2 || wr_cyc_q[0] != 3 || wr_cyc_q[1] != 5) begin
            errors++;
            $display("[TB] FAIL gapped_write_cycles: got %0d writes expected 2 at cycles 3 and 5", wr_cyc_q.size());
        end
        checks++;
        if (wr_data_q.size() != 2 || wr_data_q[0] !== word0_expect(d0 + 32'd2) || wr_data_q[1] !== d0 + 32'd4) begin
            errors++;
            $display("[TB] FAIL gapped_data: got %0d words expected %0d then %0d",
                     wr_data_q.size(), word0_expect(d0 + 32'd2), d0 + 32'd4);
        end
        checks++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] != HALF || wr_addr_q[1] != HALF + 1) begin
            errors++;
            $display("[TB] FAIL gapped_addr: got %0d writes expected addresses %0d and %0d", wr_addr_q.size(), HALF, HALF + 1);
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 6) begin
            errors++;
            $display("[TB] FAIL gapped_done: got %0d pulses first at %0d expected 1 at 6",
                     done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0]);
        end
        checks++;
        if (ready_buf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gapped_ready_buf: got %b expected 1", ready_buf);
        end
        seq_model++;
    endtask

    // Second request mid-capture sets overflow without disturbing the
    // capture; a later abort via enable=0 clears it and suppresses done.
    task automatic test_overflow();
        logic [31:0] d0;
        clear_log();
        d0 = data_ctr;
        GPIO = 32'h0F;
        step(1'b1);
        for (int s = 2; s <= 14; s++) begin
            GPIO = (s == 5) ? 32'h0F : 32'h0D;
            step(1'b1);
            if (s == 5) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL overflow_set: got %b expected 1", overflow);
                end
            end
        end
        checks++;
        if (wr_data_q.size() != 8 || wr_data_q[7] !== d0 + 32'd9 || wr_addr_q[7] != 7 || done_cyc_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL overflow_capture: got %0d writes %0d dones expected 8 writes ending at data %0d addr 7, 1 done",
                     wr_data_q.size(), done_cyc_q.size(), d0 + 32'd9);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
        end
        seq_model++;

        clear_log();
        GPIO = 32'h0F;
        step(1'b1);
        GPIO = 32'h0D;
        repeat (4) step(1'b1);
        GPIO = 32'h0;
        step(1'b1);
        checks++;
        if ({busy, overflow, axis_bus.wr_en} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got busy/overflow/wr_en %b expected 000", {busy, overflow, axis_bus.wr_en});
        end
        repeat (12) step(1'b1);
        checks++;
        if (wr_addr_q.size() != 3 || done_cyc_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL abort_activity: got %0d writes %0d dones expected 3 writes 0 dones",
                     wr_addr_q.size(), done_cyc_q.size());
        end
        checks++;
        if (wr_addr_q.size() == 0 || wr_addr_q[0] != HALF) begin
            errors++;
            $display("[TB] FAIL abort_half: got first addr %0d expected %0d",
                     (wr_addr_q.size() == 0) ? -1 : wr_addr_q[0], HALF);
        end
    endtask

    // Reset pulse mid-capture, then a fresh capture must land in half 0.
    task automatic test_reset_mid();
        clear_log();
        GPIO = 32'h0F;
        step(1'b1);
        GPIO = 32'h0D;
        repeat (4) step(1'b1);
        checks++;
        if (wr_addr_q.size() == 0 || wr_addr_q[0] != HALF) begin
            errors++;
            $display("[TB] FAIL abort_kept_half: got first addr %0d expected %0d",
                     (wr_addr_q.size() == 0) ? -1 : wr_addr_q[0], HALF);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({axis_bus.S_AXIS_tready, axis_bus.wr_en, busy, done, ready_buf, overflow} !== 6'b0 ||
            axis_bus.wr_addr !== '0 || axis_bus.wr_data !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got flags %b addr %0h data %0h expected all 0",
                     {axis_bus.S_AXIS_tready, axis_bus.wr_en, busy, done, ready_buf, overflow},
                     axis_bus.wr_addr, axis_bus.wr_data);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        seq_model = 0;
        clear_log();
        GPIO = 32'h0F;
        step(1'b1);
        GPIO = 32'h0D;
        repeat (13) step(1'b1);
        checks++;
        if (wr_addr_q.size() != 8 || wr_addr_q[0] != 0 || wr_addr_q[7] != 7) begin
            errors++;
            $display("[TB] FAIL postreset_addr: got %0d writes expected 8 at addresses 0..7", wr_addr_q.size());
        end
        checks++;
        if (done_cyc_q.size() != 1 || ready_buf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL postreset_done: got %0d dones ready_buf %b expected 1 done ready_buf 0",
                     done_cyc_q.size(), ready_buf);
        end
        seq_model++;
    endtask

`ifdef RAM_CAPTURE_SEQ_EN
    // Three captures after reset: word 0 carries 0, 1, 2.
    task automatic test_seq();
        logic [31:0] d0;
        aresetn = 1'b0;
        #1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        GPIO = 32'h05;
        checks++;
        if (seq_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL seq_reset: got %0d expected 0", seq_count);
        end
        for (int k = 0; k < 3; k++) begin
            clear_log();
            d0 = data_ctr;
            GPIO = 32'h07;
            step(1'b1);
            GPIO = 32'h05;
            repeat (5) step(1'b1);
            checks++;
            if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'(k) || wr_data_q[1] !== d0 + 32'd3) begin
                errors++;
                $display("[TB] FAIL seq_word0[%0d]: got %0d words expected %0d then %0d",
                         k, wr_data_q.size(), k, d0 + 32'd3);
            end
        end
        checks++;
        if (seq_count !== 32'd3) begin
            errors++;
            $display("[TB] FAIL seq_final: got %0d expected 3", seq_count);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        seq_model = 0;
        cyc       = 0;
        test_reset();
        test_basic();
        test_throttle();
        test_gapped();
        test_overflow();
        test_reset_mid();
`ifdef RAM_CAPTURE_SEQ_EN
        test_seq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
